// File: rtl/riscv_pkg.sv
// ---- riscv_pkg : shared types and encodings for the multicycle RV32I controller ----
// ---- rev 1.0 ----
`default_nettype none

package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

`default_nettype wire

// File: rtl/riscv_multi_aludec.sv
// ---- riscv_multi_aludec : funct3/funct7b5 to ALU operation, flags unsupported funct3 ----
// ---- rev 1.0 ----
`default_nettype none

module riscv_multi_aludec
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct3)
      3'b000:  alu_control = (funct7b5 && is_rtype) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: legal       = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_multi_controller.sv
// ---- riscv_multi_controller : multicycle RV32I control FSM with memory handshake ----
// ---- rev 1.0 ----
`default_nettype none

module riscv_multi_controller
  import riscv_pkg::*;
#(
  parameter int BRANCH_EXT    = 1,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       reg_write,
  output logic       illegal,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output state_t     state_o
);

  localparam logic EXT_OK = (BRANCH_EXT != 0);

  state_t     state;
  state_t     state_next;
  logic       rdy;
  logic [2:0] exec_alu;
  logic       exec_legal;
  logic       br_taken;
  logic       br_legal;

  assign rdy     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state_o = state;

  riscv_multi_aludec u_aludec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (state == EXECUTER),
    .alu_control (exec_alu),
    .legal       (exec_legal)
  );

  always_comb begin
    br_taken = 1'b0;
    br_legal = 1'b1;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  begin br_taken = lt;   br_legal = EXT_OK; end
      3'b101:  begin br_taken = !lt;  br_legal = EXT_OK; end
      3'b110:  begin br_taken = ltu;  br_legal = EXT_OK; end
      3'b111:  begin br_taken = !ltu; br_legal = EXT_OK; end
      default: br_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:    if (rdy) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECUTER;
          OP_ITYPE:          state_next = EXECUTEI;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          default:           state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (rdy) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: if (rdy) state_next = FETCH;
      EXECUTER, EXECUTEI: state_next = exec_legal ? ALUWB : TRAP;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = br_legal ? FETCH : TRAP;
      JAL:      state_next = ALUWB;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  // Outputs are gated by reset so nothing strobes while the state is forced to FETCH.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    if (reset) begin
      case (state)
        FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          ir_write   = rdy;
          pc_write   = rdy;
        end
        DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
        end
        MEMADR: begin
          alu_src_a = SRCA_RD1;
          alu_src_b = SRCB_IMM;
          imm_src   = (op == OP_LOAD) ? IMM_I : IMM_S;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
        end
        EXECUTER: begin
          alu_src_a   = SRCA_RD1;
          alu_control = exec_alu;
        end
        EXECUTEI: begin
          alu_src_a   = SRCA_RD1;
          alu_src_b   = SRCB_IMM;
          alu_control = exec_alu;
        end
        ALUWB:    reg_write = 1'b1;
        BRANCH: begin
          alu_src_a   = SRCA_RD1;
          alu_control = ALU_SUB;
          pc_write    = br_legal && br_taken;
        end
        JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        TRAP:     illegal = 1'b1;
        default:  illegal = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire
